// File: rtl/lsu_arbiter.sv
// Two-master round-robin arbiter in front of a single-ported LSU, with a bounded
// exclusive lock for master 1 and registered per-master read responses.
module lsu_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_m0_req,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic [3:0]        i_m0_bmask,
    input  logic              i_m0_wren,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic [3:0]        i_m1_bmask,
    input  logic              i_m1_wren,
    input  logic              i_m1_lock,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic [ADDR_W-1:0] o_lsu_addr,
    output logic [DATA_W-1:0] o_lsu_wdata,
    output logic [3:0]        o_lsu_bmask,
    output logic              o_lsu_wren,
    input  logic [DATA_W-1:0] i_lsu_rdata,
    output logic              o_lock_expired
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic {
        ST_ARB,
        ST_LOCK
    } state_t;

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              m0_rvalid_q, m1_rvalid_q;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
    logic              gnt0, gnt1, expired;

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        expired    = 1'b0;
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ST_ARB: begin
                gnt0 = i_m0_req & (~i_m1_req | last_gnt_q);
                gnt1 = i_m1_req & ~gnt0;
                if (gnt0) begin
                    last_gnt_d = 1'b0;
                end else if (gnt1) begin
                    last_gnt_d = 1'b1;
                end
                if (gnt1 && i_m1_lock) begin
                    state_d    = ST_LOCK;
                    lock_cnt_d = '0;
                end
            end
            ST_LOCK: begin
                gnt1       = i_m1_req;
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
                // Forced release is checked first so it wins over a voluntary release.
                if (lock_cnt_q == CNT_LAST) begin
                    expired    = ~i_reset;
                    state_d    = ST_ARB;
                    last_gnt_d = 1'b1;
                    lock_cnt_d = '0;
                end else if (gnt1 && !i_m1_lock) begin
                    state_d    = ST_ARB;
                    last_gnt_d = 1'b1;
                    lock_cnt_d = '0;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_comb begin
        o_lsu_addr  = '0;
        o_lsu_wdata = '0;
        o_lsu_bmask = '0;
        o_lsu_wren  = 1'b0;
        if (gnt0) begin
            o_lsu_addr  = i_m0_addr;
            o_lsu_wdata = i_m0_wdata;
            o_lsu_bmask = i_m0_bmask;
            o_lsu_wren  = i_m0_wren;
        end else if (gnt1) begin
            o_lsu_addr  = i_m1_addr;
            o_lsu_wdata = i_m1_wdata;
            o_lsu_bmask = i_m1_bmask;
            o_lsu_wren  = i_m1_wren;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_ARB;
            last_gnt_q  <= 1'b1;
            lock_cnt_q  <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            lock_cnt_q  <= lock_cnt_d;
            m0_rvalid_q <= gnt0 & ~i_m0_wren;
            m1_rvalid_q <= gnt1 & ~i_m1_wren;
            if (gnt0 && !i_m0_wren) begin
                m0_rdata_q <= i_lsu_rdata;
            end
            if (gnt1 && !i_m1_wren) begin
                m1_rdata_q <= i_lsu_rdata;
            end
        end
    end

    assign o_m0_gnt       = gnt0;
    assign o_m1_gnt       = gnt1;
    assign o_m0_rvalid    = m0_rvalid_q;
    assign o_m1_rvalid    = m1_rvalid_q;
    assign o_m0_rdata     = m0_rdata_q;
    assign o_m1_rdata     = m1_rdata_q;
    assign o_lock_expired = expired;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Scoreboard bench for lsu_arbiter: directed stimulus pushes expected read
// responses; a negedge monitor pops and checks them against rvalid/rdata.
module tb_lsu_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LM = 16;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_m0_req, i_m0_wren, i_m1_req, i_m1_wren, i_m1_lock;
    logic [AW-1:0] i_m0_addr, i_m1_addr;
    logic [DW-1:0] i_m0_wdata, i_m1_wdata;
    logic [3:0]    i_m0_bmask, i_m1_bmask;
    logic          o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid;
    logic [DW-1:0] o_m0_rdata, o_m1_rdata;
    logic [AW-1:0] o_lsu_addr;
    logic [DW-1:0] o_lsu_wdata;
    logic [3:0]    o_lsu_bmask;
    logic          o_lsu_wren;
    logic [DW-1:0] i_lsu_rdata;
    logic          o_lock_expired;

    lsu_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_req(i_m0_req), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
        .i_m0_bmask(i_m0_bmask), .i_m0_wren(i_m0_wren), .o_m0_gnt(o_m0_gnt),
        .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
        .i_m1_req(i_m1_req), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
        .i_m1_bmask(i_m1_bmask), .i_m1_wren(i_m1_wren), .i_m1_lock(i_m1_lock),
        .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
        .o_lsu_addr(o_lsu_addr), .o_lsu_wdata(o_lsu_wdata), .o_lsu_bmask(o_lsu_bmask),
        .o_lsu_wren(o_lsu_wren), .i_lsu_rdata(i_lsu_rdata), .o_lock_expired(o_lock_expired)
    );

    always #5 i_clk = ~i_clk;

    // Small word-addressed LSU model: combinational read, write at clock edge.
    logic [DW-1:0] mem [16];
    assign i_lsu_rdata = mem[o_lsu_addr[5:2]];
    always @(posedge i_clk) if (o_lsu_wren) mem[o_lsu_addr[5:2]] <= o_lsu_wdata;

    int cyc = 0;
    always @(posedge i_clk) cyc = cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (q0.size() != 0 && q0[0].cyc == cyc) begin
                exp_t e;
                e = q0.pop_front();
                chk("m0_rvalid", 32'(o_m0_rvalid), 32'd1);
                chk("m0_rdata", o_m0_rdata, e.data);
            end else begin
                chk("m0_rvalid_idle", 32'(o_m0_rvalid), 32'd0);
            end
            if (q1.size() != 0 && q1[0].cyc == cyc) begin
                exp_t e;
                e = q1.pop_front();
                chk("m1_rvalid", 32'(o_m1_rvalid), 32'd1);
                chk("m1_rdata", o_m1_rdata, e.data);
            end else begin
                chk("m1_rvalid_idle", 32'(o_m1_rvalid), 32'd0);
            end
        end
    end

    // Called 1 time unit after a rising edge with inputs already applied;
    // checks the combinational grant/LSU view and queues expected read data.
    task automatic cyc_chk(input logic eg0, input logic eg1, input logic [31:0] ed0,
                           input logic [31:0] ed1, input logic eexp, input string nm);
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        logic [3:0]    ebm;
        logic          ew;
        ea = '0; ewd = '0; ebm = '0; ew = 1'b0;
        if (eg0) begin
            ea = i_m0_addr; ewd = i_m0_wdata; ebm = i_m0_bmask; ew = i_m0_wren;
        end else if (eg1) begin
            ea = i_m1_addr; ewd = i_m1_wdata; ebm = i_m1_bmask; ew = i_m1_wren;
        end
        #1;
        chk({nm, "_gnt0"}, 32'(o_m0_gnt), 32'(eg0));
        chk({nm, "_gnt1"}, 32'(o_m1_gnt), 32'(eg1));
        chk({nm, "_lsu_addr"}, o_lsu_addr, ea);
        chk({nm, "_lsu_wdata"}, o_lsu_wdata, ewd);
        chk({nm, "_lsu_bmask"}, 32'(o_lsu_bmask), 32'(ebm));
        chk({nm, "_lsu_wren"}, 32'(o_lsu_wren), 32'(ew));
        chk({nm, "_expired"}, 32'(o_lock_expired), 32'(eexp));
        if (!i_reset) begin
            if (eg0 && !i_m0_wren) q0.push_back('{ed0, cyc + 1});
            if (eg1 && !i_m1_wren) q1.push_back('{ed1, cyc + 1});
        end
        @(posedge i_clk);
        #1;
    endtask

    localparam logic [31:0] W0 = 32'hA000_0000;
    localparam logic [31:0] W1 = 32'hA000_0001;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 | 32'(i);
        i_reset = 1'b1;
        i_m0_req = 1'b0; i_m0_addr = '0; i_m0_wdata = '0; i_m0_bmask = 4'h2; i_m0_wren = 1'b0;
        i_m1_req = 1'b0; i_m1_addr = '0; i_m1_wdata = '0; i_m1_bmask = 4'h5; i_m1_wren = 1'b0;
        i_m1_lock = 1'b0;

        @(posedge i_clk);
        #1;
        mon_en = 1'b1;
        chk("rst_m0_rvalid", 32'(o_m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(o_m1_rvalid), 32'd0);
        chk("rst_m0_rdata", o_m0_rdata, 32'd0);
        chk("rst_m1_rdata", o_m1_rdata, 32'd0);
        chk("rst_expired", 32'(o_lock_expired), 32'd0);
        chk("rst_lsu_addr", o_lsu_addr, 32'd0);
        chk("rst_lsu_wren", 32'(o_lsu_wren), 32'd0);
        chk("rst_lsu_bmask", 32'(o_lsu_bmask), 32'd0);
        chk("rst_lsu_wdata", o_lsu_wdata, 32'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // Continuous contention: strict alternation starting with m0.
        i_m0_req = 1'b1; i_m0_addr = 32'h0;
        i_m1_req = 1'b1; i_m1_addr = 32'h4;
        for (int i = 0; i < 6; i++) cyc_chk(i % 2 == 0, i % 2 != 0, W0, W1, 1'b0, "rr");

        // m0 write then read-back of the same word.
        i_m1_req = 1'b0;
        i_m0_addr = 32'h10; i_m0_wdata = DB; i_m0_wren = 1'b1;
        cyc_chk(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, "wr");
        i_m0_wdata = '0; i_m0_wren = 1'b0;
        cyc_chk(1'b1, 1'b0, DB, 32'd0, 1'b0, "rdback");
        i_m0_req = 1'b0;
        cyc_chk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, "idle0");

        // Lock held to expiry while m0 keeps requesting.
        i_m0_req = 1'b1; i_m0_addr = 32'h0;
        i_m1_req = 1'b1; i_m1_addr = 32'h4; i_m1_lock = 1'b1;
        cyc_chk(1'b0, 1'b1, W0, W1, 1'b0, "lock_entry");
        for (int i = 0; i < int'(LM); i++) cyc_chk(1'b0, 1'b1, W0, W1, i == int'(LM) - 1, "lock");
        cyc_chk(1'b1, 1'b0, W0, W1, 1'b0, "after_expire");

        // Voluntary release on the third LOCK grant.
        cyc_chk(1'b0, 1'b1, W0, W1, 1'b0, "vlock_entry");
        cyc_chk(1'b0, 1'b1, W0, W1, 1'b0, "vlock1");
        cyc_chk(1'b0, 1'b1, W0, W1, 1'b0, "vlock2");
        i_m1_lock = 1'b0;
        cyc_chk(1'b0, 1'b1, W0, W1, 1'b0, "vlock3");
        cyc_chk(1'b1, 1'b0, W0, W1, 1'b0, "vlock_exit_tie");

        // Reset in the second LOCK cycle while m1 reads.
        i_m1_lock = 1'b1;
        cyc_chk(1'b0, 1'b1, W0, W1, 1'b0, "rlock_entry");
        cyc_chk(1'b0, 1'b1, W0, W1, 1'b0, "rlock1");
        i_reset = 1'b1;
        cyc_chk(1'b0, 1'b1, W0, W1, 1'b0, "rlock2_rst");
        i_reset = 1'b0; i_m1_lock = 1'b0;
        cyc_chk(1'b1, 1'b0, W0, W1, 1'b0, "post_rst_tie");
        cyc_chk(1'b0, 1'b1, W0, W1, 1'b0, "post_rst_m1");

        // Quiet bus: outputs idle, read data retained.
        i_m0_req = 1'b0; i_m1_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc_chk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, "quiet");
            chk("quiet_m0_rdata", o_m0_rdata, W0);
            chk("quiet_m1_rdata", o_m1_rdata, W1);
        end

        @(posedge i_clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Two-master arbiter in front of the single-ported load/store unit. The CPU pipeline data port (master 0) and a secondary port (master 1: DMA/debug loader) share one LSU access per cycle. Arbitration is round-robin with a bounded bus lock for master 1. Read data is registered and returned to the owning master one cycle after grant.

## Interface
Parameters:
- ADDR_W, 32, address width of both masters and LSU side
- DATA_W, 32, data width
- LOCK_MAX, 16, maximum consecutive cycles spent in LOCK (≥2)

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_reset  in  1  synchronous reset, active-high
- i_m0_req  in  1  master 0 access request; held until granted
- i_m0_addr  in  ADDR_W  master 0 address
- i_m0_wdata  in  DATA_W  master 0 write data
- i_m0_bmask  in  4  master 0 access-size/type code, passed to LSU unchanged
- i_m0_wren  in  1  master 0 write (1) / read (0)
- o_m0_gnt  out  1  master 0 granted this cycle (combinational)
- o_m0_rvalid  out  1  master 0 read data valid (registered)
- o_m0_rdata  out  DATA_W  master 0 read data (registered)
- i_m1_req, i_m1_addr, i_m1_wdata, i_m1_bmask, i_m1_wren, o_m1_gnt, o_m1_rvalid, o_m1_rdata: same as master 0, for master 1
- i_m1_lock  in  1  master 1 requests exclusive ownership after current grant
- o_lsu_addr  out  ADDR_W  to LSU address
- o_lsu_wdata  out  DATA_W  to LSU write data
- o_lsu_bmask  out  4  to LSU byte mask / size code
- o_lsu_wren  out  1  to LSU write enable
- i_lsu_rdata  in  DATA_W  LSU combinational read data
- o_lock_expired  out  1  one-cycle pulse on forced lock release

## Operation
- States: ARB, LOCK. Other state: last_gnt (1 bit), lock_cnt (clog2(LOCK_MAX) bits), per-master rvalid/rdata registers.
- ARB grant:
  - gnt0 = m0_req & (!m1_req | last_gnt==1).
  - gnt1 = m1_req & !gnt0.
- ARB updates:
  - On any grant, last_gnt <= granted master index.
  - If gnt1 & i_m1_lock, next state LOCK and lock_cnt <= 0.
- LOCK grant: gnt0 = 0; gnt1 = m1_req. Idle cycles are allowed and the bus stays owned.
- LOCK updates:
  - lock_cnt increments each cycle.
  - Leave to ARB when gnt1 & !i_m1_lock (voluntary, no pulse), or when lock_cnt == LOCK_MAX-1 (forced).
  - On a forced exit, o_lock_expired = 1 for that cycle.
  - Forced exit takes priority if both exit conditions hold in the same cycle.
  - On either exit, last_gnt <= 1 so master 0 wins the next tie.
- LSU mux:
  - With a grant, o_lsu_* carry the granted master's fields.
  - Without a grant, o_lsu_wren=0, o_lsu_addr=0, o_lsu_wdata=0, o_lsu_bmask=0.
  - The bus never writes without a grant.
- Read response:
  - On a granted read (wren=0), the owning master's rdata <= i_lsu_rdata and rvalid <= 1 at the next edge.
  - rvalid is 0 in every other cycle.
  - rdata holds its value until the next read of that master.
- Writes: no response. The LSU commits at the edge that ends the grant cycle.
- Misaligned or unmapped accesses are not checked here. LSU data (0) is returned as-is with rvalid=1.
- Master 0 cannot lock.
- i_m1_lock is ignored unless it accompanies a master-1 grant in ARB.

## Timing
- Reset values: state=ARB, last_gnt=1, lock_cnt=0, o_m0_rvalid=o_m1_rvalid=0, o_m0_rdata=o_m1_rdata=0, o_lock_expired=0.
- With no requests in the reset cycle, all o_lsu_* are 0.
- Grant-to-LSU latency: 0 cycles (combinational). Read latency: 1 cycle from grant to rvalid.
- Throughput: one access per cycle. Back-to-back reads from one master give rvalid in consecutive cycles.
- A master must hold req and fields stable until it sees gnt high in the same cycle. Dropping req before grant cancels the access.
- Simultaneous requests in ARB alternate every cycle: 0,1,0,1 starting with 0 after reset.
- Reset asserted mid-LOCK:
  - Next cycle is ARB with lock_cnt=0.
  - A read granted in the reset cycle produces no rvalid.
  - No expired pulse.
- The LOCK entry cycle (in ARB) is not counted. At most LOCK_MAX cycles are spent in LOCK per lock.

## Test plan
- Reset, then both masters request reads at 0x0, 0x4 continuously:
  - Grants alternate m0,m1,m0,…
  - Each rvalid follows its grant by exactly 1 cycle, with the correct LSU words.
- m0 writes 0xDEADBEEF to 0x10 (word code):
  - o_lsu_wren=1 only in the grant cycle; no rvalid.
  - A subsequent m0 read of 0x10 returns 0xDEADBEEF one cycle later.
- m1 grant with lock=1, lock held, m0 requesting throughout:
  - o_m0_gnt=0 for exactly LOCK_MAX cycles.
  - o_lock_expired pulses in the final LOCK cycle.
  - m0 granted in the next cycle.
- m1 locks, then drops lock on its 3rd LOCK grant:
  - ARB next cycle, no expired pulse, m0 wins the tie.
- Reset asserted in LOCK cycle 2 while m1 reads:
  - No rvalid next cycle.
  - State ARB, m0 granted first on a tie.
- No requests for 10 cycles:
  - o_lsu_wren=0, addr/bmask/wdata=0, both rvalid=0, rdata unchanged.
